spi_master_param: RTL and testbench

Parametrised SPI master for the Nexys A7 image-processing datapath, successor to the fixed 8-bit, single-device byte master. It adds configurable word width, SCK divider, all four SPI modes (CPOL/CPHA) selected per transfer, multiple chip selects, and chip-select hold for multi-word bursts. It sits between the frame/command sequencers and external SPI peripherals (flash, ADC, display), one word per start/done handshake.

---
 rtl/spi_master_param.sv | 204 ++++++++++++++++++++
 tb/tb_spi_master_param.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spi_master_param: SPI master, runtime CPOL/CPHA, multi-CS, CS hold     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 1,
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              hold_cs,
  input  logic              cs_release,
  input  logic              miso,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int HP_W = $clog2(CLK_DIV) + 1;
  localparam int EC_W = $clog2(2 * DATA_W) + 1;
  localparam logic [HP_W-1:0] HP_LOAD = HP_W'(CLK_DIV - 1);
  localparam logic [EC_W-1:0] EC_LOAD = EC_W'(2 * DATA_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [EC_W-1:0]   ec_q, ec_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              hold_q, hold_d;

  logic [NUM_CS-1:0] sel_oh;
  logic              target_held;
  logic              hp_exp;
  logic              leading;
  logic              do_sample;
  logic              do_shift;

  // Out-of-range selects decode to all zeros, so no line is driven.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign sel_oh[gi] = (cs_sel == CS_W'(gi));
    end
  endgenerate

  assign target_held = |(sel_oh & ~cs_n_q);
  assign hp_exp      = (hp_q == '0);
  // Edges are numbered from 1 while ec counts down from 2*DATA_W, so odd
  // (leading) edges coincide with an even count.
  assign leading     = ~ec_q[0];
  assign do_sample   = cpha_q ? ~leading : leading;
  assign do_shift    = cpha_q ? leading : (~leading && (ec_q != EC_W'(1)));

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    ec_d    = ec_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cpol_d = cpol;
          cpha_d = cpha;
          hold_d = hold_cs;
          busy_d = 1'b1;
          sck_d  = cpol;
          hp_d   = HP_LOAD;
          rx_d   = '0;
          if (!cpha) begin
            mosi_d = din[DATA_W-1];
            tx_d   = {din[DATA_W-2:0], 1'b0};
          end else begin
            tx_d   = din;
          end
          if (target_held) begin
            ec_d    = EC_LOAD;
            state_d = S_XFER;
          end else begin
            cs_n_d  = ~sel_oh;
            state_d = S_SETUP;
          end
        end else if (cs_release) begin
          cs_n_d = '1;
        end
      end
      S_SETUP: begin
        if (hp_exp) begin
          hp_d    = HP_LOAD;
          ec_d    = EC_LOAD;
          state_d = S_XFER;
        end else begin
          hp_d = hp_q - HP_W'(1);
        end
      end
      S_XFER: begin
        if (hp_exp) begin
          hp_d  = HP_LOAD;
          sck_d = ~sck_q;
          ec_d  = ec_q - EC_W'(1);
          if (do_sample) rx_d = {rx_q[DATA_W-2:0], miso};
          if (do_shift) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (ec_q == EC_W'(1)) state_d = S_TRAIL;
        end else begin
          hp_d = hp_q - HP_W'(1);
        end
      end
      S_TRAIL: begin
        if (hp_exp) begin
          mosi_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dout_d  = rx_q;
          if (!hold_q) cs_n_d = '1;
          state_d = S_DONE;
        end else begin
          hp_d = hp_q - HP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hp_q    <= '0;
      ec_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b1;
      cs_n_q  <= '1;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      ec_q    <= ec_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      hold_q  <= hold_d;
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_spi_master_param: scoreboard bench for spi_master_param             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_spi_master_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  // 8-bit, 4-CS instance
  logic       start8 = 1'b0, cpol8 = 1'b0, cpha8 = 1'b0, hold8 = 1'b0, rel8 = 1'b0;
  logic       loop8 = 1'b1;
  logic [7:0] din8 = 8'h00;
  logic [1:0] sel8 = 2'd0;
  logic [7:0] dout8;
  logic       busy8, done8, sck8, mosi8, miso8;
  logic [3:0] cs8;

  // Mode-3 slave: drives on falling sck, captures on rising sck once armed.
  logic       slave_en = 1'b0, slave_armed = 1'b0, slave_miso = 1'b1;
  logic [7:0] slave_sh = 8'h3C, slave_rx = 8'h00;
  assign miso8 = loop8 ? mosi8 : slave_miso;

  always @(negedge sck8 or negedge slave_en) begin
    if (!slave_en) begin
      slave_armed <= 1'b0;
      slave_sh    <= 8'h3C;
      slave_miso  <= 1'b1;
    end else begin
      slave_armed <= 1'b1;
      slave_miso  <= slave_sh[7];
      slave_sh    <= {slave_sh[6:0], 1'b0};
    end
  end
  always @(posedge sck8) if (slave_en && slave_armed) slave_rx <= {slave_rx[6:0], mosi8};

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .din(din8), .cpol(cpol8), .cpha(cpha8),
    .cs_sel(sel8), .hold_cs(hold8), .cs_release(rel8), .miso(miso8),
    .dout(dout8), .busy(busy8), .done(done8), .sck(sck8), .mosi(mosi8), .cs_n(cs8)
  );

  // 16-bit, single-CS loopback instance
  logic        start16 = 1'b0, cpol16 = 1'b0, cpha16 = 1'b0, hold16 = 1'b0, rel16 = 1'b0;
  logic [15:0] din16 = 16'h0000;
  logic [0:0]  sel16 = 1'b0;
  logic [15:0] dout16;
  logic        busy16, done16, sck16, mosi16, miso16;
  logic [0:0]  cs16;
  assign miso16 = mosi16;

  spi_master_param #(.DATA_W(16), .CLK_DIV(2), .NUM_CS(1)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .din(din16), .cpol(cpol16), .cpha(cpha16),
    .cs_sel(sel16), .hold_cs(hold16), .cs_release(rel16), .miso(miso16),
    .dout(dout16), .busy(busy16), .done(done16), .sck(sck16), .mosi(mosi16), .cs_n(cs16)
  );

  logic use16 = 1'b0;
  wire [15:0] m_dout = use16 ? dout16 : {8'h00, dout8};
  wire        m_busy = use16 ? busy16 : busy8;
  wire        m_done = use16 ? done16 : done8;
  wire        m_sck  = use16 ? sck16  : sck8;
  wire        m_mosi = use16 ? mosi16 : mosi8;
  wire [3:0]  m_cs   = use16 ? {3'b111, cs16} : cs8;

  task automatic send(input logic [15:0] d, input logic pol, input logic pha,
                      input logic [1:0] sel, input logic hold);
    if (use16) begin
      din16 = d; cpol16 = pol; cpha16 = pha; sel16 = sel[0]; hold16 = hold; start16 = 1'b1;
    end else begin
      din8 = d[7:0]; cpol8 = pol; cpha8 = pha; sel8 = sel; hold8 = hold; start8 = 1'b1;
    end
    @(posedge clk);
    #1;
    start8 = 1'b0;
    start16 = 1'b0;
  endtask

  // Watches one transfer until done; returns at the negedge inside the done cycle.
  task automatic run_xfer(input int max_cyc, input logic [3:0] cs_exp, output int busy_n,
                          output int rises, output int bad_mosi, output int cs_bad,
                          output bit got_done);
    logic psck, pmosi;
    busy_n = 0; rises = 0; bad_mosi = 0; cs_bad = 0; got_done = 1'b0;
    psck = m_sck; pmosi = m_mosi;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (m_busy) busy_n++;
      if (m_sck && !psck) rises++;
      if ((m_mosi !== pmosi) && m_sck && !psck) bad_mosi++;
      if (m_busy && (m_cs !== cs_exp)) cs_bad++;
      psck = m_sck; pmosi = m_mosi;
      if (m_done) begin
        got_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sck8 !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b expected 0", sck8); end
    checks++; if (mosi8 !== 1'b1) begin errors++; $display("FAIL rst_mosi: got %b expected 1", mosi8); end
    checks++; if (cs8 !== 4'hF) begin errors++; $display("FAIL rst_cs: got %h expected f", cs8); end
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b%b expected 00", busy8, done8); end
    checks++; if (dout8 !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h expected 00", dout8); end
    checks++; if (dout16 !== 16'h0 || cs16 !== 1'b1) begin errors++; $display("FAIL rst_dut16: got %h/%b expected 0000/1", dout16, cs16); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode0_loopback;
    int bn, ri, bm, cb; bit gd; logic [15:0] e;
    loop8 = 1'b1;
    exp_q.push_back(16'h00A5);
    send(16'h00A5, 1'b0, 1'b0, 2'd0, 1'b0);
    run_xfer(200, 4'b1110, bn, ri, bm, cb, gd);
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL m0_done_seen: got %b expected 1", gd); end
    e = exp_q.pop_front();
    checks++; if (m_dout !== e) begin errors++; $display("FAIL m0_dout: got %h expected %h", m_dout, e); end
    checks++; if (bn !== 36) begin errors++; $display("FAIL m0_busy_len: got %0d expected 36", bn); end
    checks++; if (ri !== 8) begin errors++; $display("FAIL m0_sck_rises: got %0d expected 8", ri); end
    checks++; if (cb !== 0) begin errors++; $display("FAIL m0_cs: got %0d bad cycles expected 0", cb); end
    @(negedge clk);
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL m0_done_width: got %b expected 0", done8); end
    checks++; if (sck8 !== 1'b0 || cs8 !== 4'hF) begin errors++; $display("FAIL m0_idle: got sck=%b cs=%h expected 0/f", sck8, cs8); end
  endtask

  task automatic test_mode3_slave;
    int bn, ri, bm, cb; bit gd; logic [15:0] e;
    loop8 = 1'b0;
    slave_en = 1'b1;
    exp_q.push_back(16'h003C);
    send(16'h00C3, 1'b1, 1'b1, 2'd1, 1'b0);
    run_xfer(200, 4'b1101, bn, ri, bm, cb, gd);
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL m3_done_seen: got %b expected 1", gd); end
    e = exp_q.pop_front();
    checks++; if (m_dout !== e) begin errors++; $display("FAIL m3_dout: got %h expected %h", m_dout, e); end
    checks++; if (slave_rx !== 8'hC3) begin errors++; $display("FAIL m3_slave_rx: got %h expected c3", slave_rx); end
    checks++; if (bm !== 0) begin errors++; $display("FAIL m3_mosi_on_rise: got %0d expected 0", bm); end
    checks++; if (sck8 !== 1'b1) begin errors++; $display("FAIL m3_sck_idle: got %b expected 1", sck8); end
    checks++; if (bn !== 36 || cb !== 0) begin errors++; $display("FAIL m3_busy_cs: got busy=%0d csbad=%0d expected 36/0", bn, cb); end
    slave_en = 1'b0;
    loop8 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_burst;
    int bn, ri, bm, cb; bit gd; logic [15:0] e;
    exp_q.push_back(16'h0011);
    send(16'h0011, 1'b0, 1'b0, 2'd2, 1'b1);
    run_xfer(200, 4'b1011, bn, ri, bm, cb, gd);
    e = exp_q.pop_front();
    checks++; if (gd !== 1'b1 || m_dout !== e) begin errors++; $display("FAIL burst1_dout: got %h done=%b expected %h", m_dout, gd, e); end
    checks++; if (cs8 !== 4'b1011) begin errors++; $display("FAIL burst1_cs_done: got %b expected 1011", cs8); end
    @(negedge clk);
    checks++; if (cs8 !== 4'b1011 || done8 !== 1'b0) begin errors++; $display("FAIL burst_gap: got cs=%b done=%b expected 1011/0", cs8, done8); end
    exp_q.push_back(16'h0022);
    send(16'h0022, 1'b0, 1'b0, 2'd2, 1'b0);
    run_xfer(200, 4'b1011, bn, ri, bm, cb, gd);
    e = exp_q.pop_front();
    checks++; if (gd !== 1'b1 || m_dout !== e) begin errors++; $display("FAIL burst2_dout: got %h done=%b expected %h", m_dout, gd, e); end
    checks++; if (bn !== 34) begin errors++; $display("FAIL burst2_busy_len: got %0d expected 34", bn); end
    checks++; if (cb !== 0) begin errors++; $display("FAIL burst_cs_hold: got %0d bad cycles expected 0", cb); end
    checks++; if (cs8 !== 4'hF) begin errors++; $display("FAIL burst2_cs_release: got %h expected f", cs8); end
    @(negedge clk);
  endtask

  task automatic test_held_switch;
    int bn, ri, bm, cb; bit gd; logic [15:0] e;
    exp_q.push_back(16'h005A);
    send(16'h005A, 1'b0, 1'b0, 2'd1, 1'b1);
    run_xfer(200, 4'b1101, bn, ri, bm, cb, gd);
    e = exp_q.pop_front();
    checks++; if (gd !== 1'b1 || m_dout !== e || cs8 !== 4'b1101) begin errors++; $display("FAIL sw1: got dout=%h cs=%b expected %h/1101", m_dout, cs8, e); end
    @(negedge clk);
    exp_q.push_back(16'h0069);
    send(16'h0069, 1'b0, 1'b0, 2'd3, 1'b0);
    checks++; if (cs8 !== 4'b0111) begin errors++; $display("FAIL sw_cs_swap: got %b expected 0111", cs8); end
    run_xfer(200, 4'b0111, bn, ri, bm, cb, gd);
    e = exp_q.pop_front();
    checks++; if (gd !== 1'b1 || m_dout !== e) begin errors++; $display("FAIL sw2_dout: got %h expected %h", m_dout, e); end
    checks++; if (bn !== 36 || cb !== 0) begin errors++; $display("FAIL sw2_setup: got busy=%0d csbad=%0d expected 36/0", bn, cb); end
    @(negedge clk);
  endtask

  task automatic test_cs_release;
    int bn, ri, bm, cb; bit gd; logic [15:0] e;
    exp_q.push_back(16'h0033);
    send(16'h0033, 1'b0, 1'b0, 2'd0, 1'b1);
    run_xfer(200, 4'b1110, bn, ri, bm, cb, gd);
    e = exp_q.pop_front();
    checks++; if (gd !== 1'b1 || m_dout !== e) begin errors++; $display("FAIL rel_dout: got %h expected %h", m_dout, e); end
    @(negedge clk);
    checks++; if (cs8 !== 4'b1110) begin errors++; $display("FAIL rel_held: got %b expected 1110", cs8); end
    rel8 = 1'b1;
    @(posedge clk);
    #1;
    rel8 = 1'b0;
    checks++; if (cs8 !== 4'hF || busy8 !== 1'b0) begin errors++; $display("FAIL rel_cs: got cs=%h busy=%b expected f/0", cs8, busy8); end
    @(negedge clk);
  endtask

  task automatic test_start_busy;
    int bn, ri, bm, cb, extra; bit gd; logic [15:0] e;
    exp_q.push_back(16'h0096);
    send(16'h0096, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (10) @(negedge clk);
    din8 = 8'hFF;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    run_xfer(200, 4'b1110, bn, ri, bm, cb, gd);
    e = exp_q.pop_front();
    checks++; if (gd !== 1'b1 || m_dout !== e) begin errors++; $display("FAIL sb_dout: got %h expected %h", m_dout, e); end
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy8 || done8) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL sb_no_second: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid;
    int extra;
    send(16'h0000, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (17) @(negedge clk);
    checks++; if (sck8 !== 1'b1 || mosi8 !== 1'b0 || cs8 !== 4'b1110) begin errors++; $display("FAIL rm_pre: got sck=%b mosi=%b cs=%b expected 1/0/1110", sck8, mosi8, cs8); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (sck8 !== 1'b0 || mosi8 !== 1'b1) begin errors++; $display("FAIL rm_lines: got sck=%b mosi=%b expected 0/1", sck8, mosi8); end
    checks++; if (cs8 !== 4'hF || busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL rm_ctl: got cs=%h busy=%b done=%b expected f/0/0", cs8, busy8, done8); end
    checks++; if (dout8 !== 8'h00) begin errors++; $display("FAIL rm_dout: got %h expected 00", dout8); end
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy8 || done8) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL rm_quiet: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_width16;
    int bn, ri, bm, cb; bit gd; logic [15:0] e;
    use16 = 1'b1;
    exp_q.push_back(16'hBEEF);
    send(16'hBEEF, 1'b0, 1'b0, 2'd0, 1'b0);
    run_xfer(300, 4'b1110, bn, ri, bm, cb, gd);
    e = exp_q.pop_front();
    checks++; if (gd !== 1'b1 || m_dout !== e) begin errors++; $display("FAIL w16_dout: got %h expected %h", m_dout, e); end
    checks++; if (bn !== 68) begin errors++; $display("FAIL w16_busy_len: got %0d expected 68", bn); end
    checks++; if (ri !== 16 || cb !== 0) begin errors++; $display("FAIL w16_sck_cs: got rises=%0d csbad=%0d expected 16/0", ri, cb); end
    @(negedge clk);
    checks++; if (cs16 !== 1'b1 || done16 !== 1'b0) begin errors++; $display("FAIL w16_idle: got cs=%b done=%b expected 1/0", cs16, done16); end
    use16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_mode3_slave();
    test_burst();
    test_held_switch();
    test_cs_release();
    test_start_busy();
    test_reset_mid();
    test_width16();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
